// File: rtl/tq_tr4_pipe.sv
// Pipelined 4-point HEVC DST/DCT (forward or inverse) with rounding shift, saturation
// and a valid/ready handshake; one 4-sample vector per cycle, three register stages.
module tq_tr4_pipe #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_mode,
  input  logic                    i_inverse,
  input  logic [3:0]              i_shift,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic signed [IN_W-1:0]  i_0,
  input  logic signed [IN_W-1:0]  i_1,
  input  logic signed [IN_W-1:0]  i_2,
  input  logic signed [IN_W-1:0]  i_3,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [TAG_W-1:0]        o_tag,
  output logic signed [OUT_W-1:0] o_0,
  output logic signed [OUT_W-1:0] o_1,
  output logic signed [OUT_W-1:0] o_2,
  output logic signed [OUT_W-1:0] o_3
);

  localparam int PROD_W = IN_W + 8;
  localparam int PSUM_W = IN_W + 9;
  localparam int ACC_W  = IN_W + 10;
  localparam int RND_W  = ACC_W + 1;

  // Row-major forward matrices, indexed by {row, col}.
  localparam logic signed [7:0] DST_M [16] = '{
    8'sd29,  8'sd55,  8'sd74,  8'sd84,
    8'sd74,  8'sd74,  8'sd0,  -8'sd74,
    8'sd84, -8'sd29, -8'sd74,  8'sd55,
    8'sd55, -8'sd84,  8'sd74, -8'sd29};
  localparam logic signed [7:0] DCT_M [16] = '{
    8'sd64,  8'sd64,  8'sd64,  8'sd64,
    8'sd83,  8'sd36, -8'sd36, -8'sd83,
    8'sd64, -8'sd64, -8'sd64,  8'sd64,
    8'sd36, -8'sd83,  8'sd83, -8'sd36};

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [PROD_W-1:0] mul(input logic mode, input logic inv,
                                                   input int k, input int j,
                                                   input logic signed [IN_W-1:0] x);
    logic [1:0]        r;
    logic [1:0]        c;
    logic signed [7:0] cf;
    // Inverse reads the matrix transposed: output k uses column k.
    r  = inv ? 2'(j) : 2'(k);
    c  = inv ? 2'(k) : 2'(j);
    cf = mode ? DCT_M[{r, c}] : DST_M[{r, c}];
    return PROD_W'(cf) * PROD_W'(x);
  endfunction

  logic                     w_stall;
  logic signed [IN_W-1:0]   w_x    [4];
  logic signed [PSUM_W-1:0] w_psum [4][2];
  logic signed [OUT_W-1:0]  w_res  [4];

  logic                     r_s1_valid;
  logic signed [PSUM_W-1:0] r_s1_psum [4][2];
  logic [3:0]               r_s1_shift;
  logic [TAG_W-1:0]         r_s1_tag;

  logic                     r_s2_valid;
  logic signed [ACC_W-1:0]  r_s2_acc [4];
  logic [3:0]               r_s2_shift;
  logic [TAG_W-1:0]         r_s2_tag;

  logic                     r_s3_valid;
  logic signed [OUT_W-1:0]  r_s3_out [4];
  logic [TAG_W-1:0]         r_s3_tag;

  assign w_stall = r_s3_valid && !o_ready;
  assign i_ready = !w_stall;

  assign w_x[0] = i_0;
  assign w_x[1] = i_1;
  assign w_x[2] = i_2;
  assign w_x[3] = i_3;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 2; h++) begin
        w_psum[k][h] = PSUM_W'(mul(i_mode, i_inverse, k, 2 * h, w_x[2 * h]))
                     + PSUM_W'(mul(i_mode, i_inverse, k, 2 * h + 1, w_x[2 * h + 1]));
      end
    end
  end

  always_comb begin : round_sat
    logic signed [RND_W-1:0] w_bias;
    logic signed [RND_W-1:0] w_sum;
    logic signed [RND_W-1:0] w_shr;
    w_bias = '0;
    w_sum  = '0;
    w_shr  = '0;
    for (int k = 0; k < 4; k++) begin
      w_bias = (r_s2_shift == 4'd0) ? '0 : (RND_W'(1) << (r_s2_shift - 4'd1));
      w_sum  = RND_W'(r_s2_acc[k]) + w_bias;
      w_shr  = w_sum >>> r_s2_shift;
      if (w_shr > SAT_MAX) begin
        w_res[k] = OUT_W'(SAT_MAX);
      end else if (w_shr < SAT_MIN) begin
        w_res[k] = OUT_W'(SAT_MIN);
      end else begin
        w_res[k] = OUT_W'(w_shr);
      end
    end
  end

  // Global stall: every stage holds together, bubbles advance when not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_shift <= '0;
      r_s2_shift <= '0;
      r_s1_tag   <= '0;
      r_s2_tag   <= '0;
      r_s3_tag   <= '0;
      for (int k = 0; k < 4; k++) begin
        r_s1_psum[k][0] <= '0;
        r_s1_psum[k][1] <= '0;
        r_s2_acc[k]     <= '0;
        r_s3_out[k]     <= '0;
      end
    end else if (!w_stall) begin
      r_s1_valid <= i_valid;
      r_s1_shift <= i_shift;
      r_s1_tag   <= i_tag;
      r_s2_valid <= r_s1_valid;
      r_s2_shift <= r_s1_shift;
      r_s2_tag   <= r_s1_tag;
      r_s3_valid <= r_s2_valid;
      r_s3_tag   <= r_s2_tag;
      for (int k = 0; k < 4; k++) begin
        r_s1_psum[k][0] <= w_psum[k][0];
        r_s1_psum[k][1] <= w_psum[k][1];
        r_s2_acc[k]     <= ACC_W'(r_s1_psum[k][0]) + ACC_W'(r_s1_psum[k][1]);
        r_s3_out[k]     <= w_res[k];
      end
    end
  end

  assign o_valid = r_s3_valid;
  assign o_tag   = r_s3_tag;
  assign o_0     = r_s3_out[0];
  assign o_1     = r_s3_out[1];
  assign o_2     = r_s3_out[2];
  assign o_3     = r_s3_out[3];

endmodule

// File: tb/tb_tq_tr4_pipe.sv
// Scoreboard bench for tq_tr4_pipe: directed vectors, a backpressured random stream
// checked against an integer reference model, and a mid-stream reset.
module tb_tq_tr4_pipe;

  localparam int IN_W  = 19;
  localparam int OUT_W = 16;
  localparam int TAG_W = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_valid = 1'b0;
  logic                    i_ready;
  logic                    i_mode = 1'b0;
  logic                    i_inverse = 1'b0;
  logic [3:0]              i_shift = '0;
  logic [TAG_W-1:0]        i_tag = '0;
  logic signed [IN_W-1:0]  i_0 = '0;
  logic signed [IN_W-1:0]  i_1 = '0;
  logic signed [IN_W-1:0]  i_2 = '0;
  logic signed [IN_W-1:0]  i_3 = '0;
  logic                    o_valid;
  logic                    o_ready = 1'b1;
  logic [TAG_W-1:0]        o_tag;
  logic signed [OUT_W-1:0] o_0;
  logic signed [OUT_W-1:0] o_1;
  logic signed [OUT_W-1:0] o_2;
  logic signed [OUT_W-1:0] o_3;

  tq_tr4_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_mode    (i_mode),
    .i_inverse (i_inverse),
    .i_shift   (i_shift),
    .i_tag     (i_tag),
    .i_0       (i_0),
    .i_1       (i_1),
    .i_2       (i_2),
    .i_3       (i_3),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_tag     (o_tag),
    .o_0       (o_0),
    .o_1       (o_1),
    .o_2       (o_2),
    .o_3       (o_3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sb_tag [$];
  int sb_o   [$];

  bit ready_manual = 1'b1;
  bit bp_en = 1'b0;

  int dst_m [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74},
                       '{84, -29, -74, 55}, '{55, -84, 74, -29}};
  int dct_m [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                       '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_out(bit mode, bit inv, int sh, int x0, int x1, int x2, int x3,
                                   int k);
    longint xs [4];
    longint acc;
    int     m;
    xs  = '{longint'(x0), longint'(x1), longint'(x2), longint'(x3)};
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      if (mode) m = inv ? dct_m[j][k] : dct_m[k][j];
      else      m = inv ? dst_m[j][k] : dst_m[k][j];
      acc += longint'(m) * xs[j];
    end
    if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  // Drives one vector, waits for acceptance and queues its expected result.
  task automatic send(input bit mode, input bit inv, input int sh, input int tag,
                      input int x0, input int x1, input int x2, input int x3,
                      input int e0, input int e1, input int e2, input int e3);
    bit accepted;
    i_mode    = mode;
    i_inverse = inv;
    i_shift   = 4'(sh);
    i_tag     = TAG_W'(tag);
    i_0       = IN_W'(x0);
    i_1       = IN_W'(x1);
    i_2       = IN_W'(x2);
    i_3       = IN_W'(x3);
    i_valid   = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (i_ready) begin
        accepted = 1'b1;
        sb_tag.push_back(tag);
        sb_o.push_back(e0);
        sb_o.push_back(e1);
        sb_o.push_back(e2);
        sb_o.push_back(e3);
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!accepted) check_eq("accept_timeout", longint'(i_ready), 1);
  endtask

  task automatic send_m(input bit mode, input bit inv, input int sh, input int tag,
                        input int x0, input int x1, input int x2, input int x3);
    send(mode, inv, sh, tag, x0, x1, x2, x3,
         model_out(mode, inv, sh, x0, x1, x2, x3, 0), model_out(mode, inv, sh, x0, x1, x2, x3, 1),
         model_out(mode, inv, sh, x0, x1, x2, x3, 2), model_out(mode, inv, sh, x0, x1, x2, x3, 3));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb_tag.size() != 0; n++) @(posedge clk);
    #1;
    check_eq("drain", longint'(sb_tag.size()), 0);
  endtask

  // o_ready source: manual level, or pseudo-random with forced 5-cycle low runs.
  int low_run = 0;
  bit bp_q = 1'b0;
  always @(posedge clk) begin
    #2;
    if (bp_en) begin
      if (!bp_q) low_run = 5;
      if (low_run > 0) begin
        o_ready = 1'b0;
        low_run--;
      end else if ($urandom_range(0, 7) == 0) begin
        o_ready = 1'b0;
        low_run = 4;
      end else begin
        o_ready = ($urandom_range(0, 3) != 0);
      end
    end else begin
      o_ready = ready_manual;
    end
    bp_q = bp_en;
  end

  // Output monitor: pops the scoreboard on each transfer and checks stall stability.
  bit                      hold = 1'b0;
  logic signed [OUT_W-1:0] h_o [4];
  logic [TAG_W-1:0]        h_tag;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check_eq("hold_valid", longint'(o_valid), 1);
        check_eq("hold_tag", longint'(o_tag), longint'(h_tag));
        check_eq("hold_o0", longint'(o_0), longint'(h_o[0]));
        check_eq("hold_o1", longint'(o_1), longint'(h_o[1]));
        check_eq("hold_o2", longint'(o_2), longint'(h_o[2]));
        check_eq("hold_o3", longint'(o_3), longint'(h_o[3]));
      end
      if (o_valid && o_ready) begin
        if (sb_tag.size() == 0) begin
          check_eq("unexpected_output_q", longint'(sb_tag.size()), 1);
        end else begin
          check_eq("out_tag", longint'(o_tag), longint'(sb_tag.pop_front()));
          check_eq("out_o0", longint'(o_0), longint'(sb_o.pop_front()));
          check_eq("out_o1", longint'(o_1), longint'(sb_o.pop_front()));
          check_eq("out_o2", longint'(o_2), longint'(sb_o.pop_front()));
          check_eq("out_o3", longint'(o_3), longint'(sb_o.pop_front()));
        end
      end
      hold  = o_valid && !o_ready;
      h_o   = '{o_0, o_1, o_2, o_3};
      h_tag = o_tag;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_o_valid", longint'(o_valid), 0);
    check_eq("rst_o_tag", longint'(o_tag), 0);
    check_eq("rst_o0", longint'(o_0), 0);
    check_eq("rst_o3", longint'(o_3), 0);
    check_eq("rst_i_ready", longint'(i_ready), 1);
    @(posedge clk);
    #1;

    // Directed vectors back-to-back with changing configuration.
    send(1'b0, 1'b0, 0, 1, 1, 0, 0, 0, 29, 74, 84, 55);
    send(1'b0, 1'b1, 0, 2, 1, 0, 0, 0, 29, 55, 74, 84);
    send(1'b1, 1'b0, 0, 3, 1, 1, 1, 1, 256, 0, 0, 0);
    send(1'b1, 1'b0, 8, 4, 1, 1, 1, 1, 1, 0, 0, 0);
    send(1'b1, 1'b0, 7, 5, 1, 0, 0, 0, 1, 1, 1, 0);
    send(1'b0, 1'b0, 1, 6, -1, 0, 0, 0, -14, -37, -42, -27);
    send(1'b0, 1'b0, 0, 7, 262143, 262143, 262143, 262143, 32767, 32767, 32767, 32767);
    send(1'b0, 1'b0, 0, 8, -262144, -262144, -262144, -262144,
         -32768, -32768, -32768, -32768);
    drain();

    // Randomised stream under backpressure.
    bp_en = 1'b1;
    for (int v = 0; v < 20; v++) begin
      int xs [4];
      for (int j = 0; j < 4; j++) begin
        if (v % 4 == 3) xs[j] = int'($urandom_range(0, 524287)) - 262144;
        else            xs[j] = int'($urandom_range(0, 16383)) - 8192;
      end
      send_m(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             16 + v, xs[0], xs[1], xs[2], xs[3]);
    end
    drain();
    bp_en = 1'b0;
    ready_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Three vectors in flight and stalled, then a one-cycle reset.
    send_m(1'b0, 1'b0, 0, 100, 5, 6, 7, 8);
    send_m(1'b1, 1'b1, 2, 101, 9, -3, 4, 1);
    send_m(1'b0, 1'b1, 1, 102, -7, 2, 0, 3);
    rst = 1'b1;
    sb_tag.delete();
    sb_o.delete();
    ready_manual = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_o_valid", longint'(o_valid), 0);
    check_eq("mid_rst_o0", longint'(o_0), 0);
    check_eq("mid_rst_o1", longint'(o_1), 0);
    check_eq("mid_rst_tag", longint'(o_tag), 0);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 0, 119, 1, 1, 1, 1, 256, 0, 0, 0);
    @(negedge clk);
    check_eq("lat_c1_valid", longint'(o_valid), 0);
    @(negedge clk);
    check_eq("lat_c2_valid", longint'(o_valid), 0);
    @(negedge clk);
    check_eq("lat_c3_valid", longint'(o_valid), 1);
    check_eq("lat_c3_tag", longint'(o_tag), 119);
    drain();
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_quiet_valid", longint'(o_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tq_tr4_pipe.md
# tq_tr4_pipe

Parametrised, pipelined 4-point integer transform for the TQ path. It computes the HEVC 4x4 DST (luma intra) or the 4-point DCT, forward or inverse, on one 4-sample row or column per cycle. It adds rounding shift, output saturation and a valid/ready handshake with backpressure. It sits between the TQ transpose buffer and the quantiser/reconstruction path and supersedes the fixed-width, handshake-less 4-point DST stage.

## Interface
- IN_W, 19: signed input sample width
- OUT_W, 16: signed output sample width after shift/saturation
- TAG_W, 8: width of opaque sideband tag carried alongside each vector
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input vector valid
- i_ready  out  1  block can accept a vector this cycle
- i_mode  in  1  0 = DST, 1 = DCT
- i_inverse  in  1  0 = forward matrix, 1 = transposed (inverse) matrix
- i_shift  in  4  right-shift amount 0..15 applied after accumulation
- i_tag  in  TAG_W  sideband, returned unchanged with result
- i_0..i_3  in  IN_W each  signed input samples
- o_valid  out  1  output vector valid
- o_ready  in  1  downstream accepts output
- o_tag  out  TAG_W  tag of the vector on o_0..o_3
- o_0..o_3  out  OUT_W each  signed results

## Operation
- Transfer: input on i_valid && i_ready; output on o_valid && o_ready.
- Forward DST matrix rows (coefficients applied to i_0..i_3):
  - row 0: 29 55 74 84
  - row 1: 74 74 0 -74
  - row 2: 84 -29 -74 55
  - row 3: 55 -84 74 -29
- Forward DCT matrix rows:
  - row 0: 64 64 64 64
  - row 1: 83 36 -36 -83
  - row 2: 64 -64 -64 64
  - row 3: 36 -83 83 -36
- Inverse uses the transpose of the selected matrix: o_k = sum_j M[j][k]·i_j.
- mode, inverse, shift and tag are captured per vector with the samples and travel down the pipeline. Consecutive vectors may use different configurations with no bubble.
- Arithmetic:
  - Products are IN_W+8 bits.
  - Accumulator ACC_W = IN_W+10, full precision, no intermediate truncation.
  - Rounding: shift=0 → value unchanged; otherwise (acc + (1<<(shift-1))) >>> shift. This is an arithmetic shift, rounding half toward +inf.
  - Saturation: clamp to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Pipeline, 3 stages, each with its own valid bit:
  - S1 registers the 8 pairwise partial sums (coeff·i_a + coeff·i_b) for the selected matrix.
  - S2 registers the 4 full sums.
  - S3 registers the rounded, saturated results and the tag; S3 drives o_*.
- Flow control is a global stall: stall = o_valid && !o_ready. While stalled, all stage registers and valid bits hold. i_ready = !stall.
- Bubbles are not compacted; an empty stage still advances when not stalled.

## Timing
- Latency: a vector accepted in cycle t appears on o_* at cycle t+3 when there is no stall. Each stall cycle adds one.
- Throughput: 1 vector/cycle while o_ready=1.
- i_ready is combinational from o_valid and o_ready. There is no combinational path from i_* to o_*.
- o_* and o_tag are stable while o_valid && !o_ready.
- Reset: all stage valid bits clear. o_valid=0, o_0..o_3=0, o_tag=0. i_ready=1 in the cycle after rst deasserts.
- Reset mid-stream: every in-flight vector is discarded and none is emitted afterwards. An input presented in a cycle with rst=1 is not accepted.
- An input offered during a stall is not accepted; the source must hold it.
- Simultaneous output accept and input accept in one cycle is legal and loses nothing.

## Test plan
- DST forward impulse: i=(1,0,0,0), shift 0 → o=(29,74,84,55) three cycles after acceptance. Same vector with inverse=1 → o=(29,55,74,84).
- DCT forward DC: i=(1,1,1,1), shift 0 → (256,0,0,0). With shift 8 → (1,0,0,0).
- Rounding:
  - DCT forward, i=(1,0,0,0), shift 7: 64 → 1; 83 → 1; 36 → 0.
  - DST, i=(-1,0,0,0), shift 1: -29 → -14; -74 → -37; -84 → -42; -55 → -27.
- Saturation: IN_W=19, all inputs 262143, DST forward, shift 0 → o_0=32767. All inputs -262144 → o_0=-32768.
- Backpressure: stream 20 vectors with mixed mode/inverse/tag while toggling o_ready pseudo-randomly, including 5-cycle low runs. Required: output matches the reference model in order, with no loss or duplication, and o_* held stable during stalls.
- Reset mid-stream: assert rst for 1 cycle with 3 vectors in flight → o_valid=0 and outputs 0 the next cycle, none of those vectors ever emitted, and a new vector accepted right after reset completes 3 cycles later.
